hour_counter: RTL and testbench

Parametrised modulo time-unit counter, the successor to the fixed 24-hour counter in the digital clock datapath. It advances only on the carry-in from the minute stage and decrements in set mode. Loads are range-checked. It produces a registered one-cycle carry-out for the date/calendar stage. Optional 12-hour display conversion with a PM flag drives the gated display bus.

---
 rtl/hour_counter.sv | 73 +++++++
 tb/tb_hour_counter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/hour_counter.sv
// rtl/hour_counter.sv - modulo time-unit counter with carry-out, range-checked load and 12-hour display
module hour_counter #(
    parameter int WIDTH = 5,
    parameter int MOD   = 24
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             minCount,
    input  logic             dec,
    input  logic             mode12,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] display,
    output logic             pm,
    output logic [WIDTH-1:0] databus,
    output logic             hourCount,
    output logic             loadErr
);

    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MOD - 1);
    localparam logic [WIDTH-1:0] HALF_VAL = WIDTH'(MOD / 2);
    localparam logic [WIDTH-1:0] TWELVE   = WIDTH'(12);
    localparam bit               IS_DAY   = (MOD == 24);

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            count     <= '0;
            hourCount <= 1'b0;
            loadErr   <= 1'b0;
        end else begin
            hourCount <= 1'b0;
            loadErr   <= 1'b0;
            if (load) begin
                if (data <= MAX_VAL) begin
                    count <= data;
                end else begin
                    loadErr <= 1'b1;
                end
            end else if (minCount && !dec) begin
                // explicit compare-and-select so non-power-of-two moduli wrap correctly
                if (count == MAX_VAL) begin
                    count     <= '0;
                    hourCount <= 1'b1;
                end else begin
                    count <= count + 1'b1;
                end
            end else if (dec && !minCount) begin
                if (count == '0) begin
                    count <= MAX_VAL;
                end else begin
                    count <= count - 1'b1;
                end
            end
        end
    end

    always_comb begin
        display = count;
        if (IS_DAY && mode12) begin
            if (count == '0) begin
                display = TWELVE;
            end else if (count > TWELVE) begin
                display = count - TWELVE;
            end
        end
    end

    assign pm      = (count >= HALF_VAL);
    assign databus = enable ? display : '0;

endmodule

// File: tb/tb_hour_counter.sv
// tb/tb_hour_counter.sv - randomized and directed self-checking bench for hour_counter
module tb_hour_counter;

    logic       clk = 1'b0;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic       minCount = 1'b0;
    logic       dec = 1'b0;
    logic       mode12 = 1'b0;
    logic       enable = 1'b1;
    logic [4:0] d24 = '0;
    logic [3:0] d12 = '0;

    logic [4:0] count24, display24, databus24;
    logic       pm24, hc24, le24;
    logic [3:0] count12, display12, databus12;
    logic       pm12, hc12, le12;

    int n_checks = 0;
    int n_fail   = 0;

    int m_count [2];
    int m_hc    [2];
    int m_le    [2];
    int m_mod   [2] = '{24, 12};

    always #5 clk = ~clk;

    hour_counter #(.WIDTH(5), .MOD(24)) u_dut24 (
        .clk(clk), .clear(clear), .load(load), .data(d24), .minCount(minCount),
        .dec(dec), .mode12(mode12), .enable(enable), .count(count24),
        .display(display24), .pm(pm24), .databus(databus24),
        .hourCount(hc24), .loadErr(le24)
    );

    hour_counter #(.WIDTH(4), .MOD(12)) u_dut12 (
        .clk(clk), .clear(clear), .load(load), .data(d12), .minCount(minCount),
        .dec(dec), .mode12(mode12), .enable(enable), .count(count12),
        .display(display12), .pm(pm12), .databus(databus12),
        .hourCount(hc12), .loadErr(le12)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_disp(input int i);
        int h;
        if (m_mod[i] == 24 && mode12) begin
            h = m_count[i] % 12;
            return (h == 0) ? 12 : h;
        end
        return m_count[i];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_count[i] = 0;
            m_hc[i]    = 0;
            m_le[i]    = 0;
        end
    endtask

    task automatic model_edge();
        int d;
        for (int i = 0; i < 2; i++) begin
            d = (i == 0) ? int'(d24) : int'(d12);
            m_hc[i] = 0;
            m_le[i] = 0;
            if (load) begin
                if (d < m_mod[i]) m_count[i] = d;
                else              m_le[i] = 1;
            end else if (minCount && !dec) begin
                m_hc[i]    = (m_count[i] + 1 == m_mod[i]) ? 1 : 0;
                m_count[i] = (m_count[i] + 1) % m_mod[i];
            end else if (dec && !minCount) begin
                m_count[i] = (m_count[i] + m_mod[i] - 1) % m_mod[i];
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".count24"},   int'(count24),   m_count[0]);
        check({tag, ".disp24"},    int'(display24), exp_disp(0));
        check({tag, ".pm24"},      int'(pm24),      (m_count[0] >= 12) ? 1 : 0);
        check({tag, ".bus24"},     int'(databus24), enable ? exp_disp(0) : 0);
        check({tag, ".hc24"},      int'(hc24),      m_hc[0]);
        check({tag, ".le24"},      int'(le24),      m_le[0]);
        check({tag, ".count12"},   int'(count12),   m_count[1]);
        check({tag, ".disp12"},    int'(display12), exp_disp(1));
        check({tag, ".pm12"},      int'(pm12),      (m_count[1] >= 6) ? 1 : 0);
        check({tag, ".bus12"},     int'(databus12), enable ? exp_disp(1) : 0);
        check({tag, ".hc12"},      int'(hc12),      m_hc[1]);
        check({tag, ".le12"},      int'(le12),      m_le[1]);
    endtask

    // inputs are set at posedge+1; this applies them on the next edge and samples 1 ns later
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic set_req(input logic l, input logic mc, input logic dc,
                           input int v24, input int v12);
        load     = l;
        minCount = mc;
        dec      = dc;
        d24      = 5'(v24);
        d12      = 4'(v12);
    endtask

    initial begin
        model_reset();
        #1 clear = 1'b1;
        #1 check_all("reset");
        mode12 = 1'b1;
        #1 check_all("reset_m12");
        mode12 = 1'b0;

        @(posedge clk);
        #1 clear = 1'b0;

        set_req(1'b0, 1'b1, 1'b0, 0, 0);
        for (int k = 0; k < 24; k++) step("inc_sweep");
        set_req(1'b0, 1'b0, 1'b0, 0, 0);
        step("idle_after_carry");

        set_req(1'b1, 1'b0, 1'b0, 17, 11);
        step("load_ok");
        set_req(1'b1, 1'b0, 1'b0, 24, 12);
        step("load_reject");
        set_req(1'b0, 1'b0, 1'b0, 0, 0);
        step("load_err_clear");
        set_req(1'b1, 1'b0, 1'b0, 31, 15);
        step("load_reject_max");

        set_req(1'b1, 1'b0, 1'b0, 0, 0);
        step("load_zero");
        set_req(1'b0, 1'b0, 1'b1, 0, 0);
        step("dec_wrap");
        set_req(1'b1, 1'b0, 1'b0, 5, 5);
        step("load_five");
        set_req(1'b0, 1'b1, 1'b1, 0, 0);
        step("dec_inc_cancel");
        set_req(1'b1, 1'b0, 1'b0, 23, 11);
        step("load_top");
        set_req(1'b1, 1'b1, 1'b0, 9, 9);
        step("load_over_inc");

        mode12 = 1'b1;
        foreach (m_mod[i]) begin end
        for (int k = 0; k < 6; k++) begin
            int vals [6] = '{0, 1, 11, 12, 13, 23};
            set_req(1'b1, 1'b0, 1'b0, vals[k], vals[k] % 12);
            step("m12_sweep");
        end
        set_req(1'b1, 1'b0, 1'b0, 13, 1);
        step("m12_at13");
        set_req(1'b0, 1'b0, 1'b0, 0, 0);
        mode12 = 1'b0;
        #1 check_all("m12_toggle");

        enable = 1'b0;
        set_req(1'b0, 1'b1, 1'b0, 0, 0);
        for (int k = 0; k < 12; k++) step("bus_off");
        enable = 1'b1;
        for (int k = 0; k < 4; k++) step("bus_on");

        set_req(1'b1, 1'b0, 1'b0, 23, 11);
        step("pre_carry");
        set_req(1'b0, 1'b1, 1'b0, 0, 0);
        step("carry_pulse");
        check("carry_seen", int'(hc24), 1);
        #1 clear = 1'b1;
        model_reset();
        #1 check_all("async_clear");
        @(posedge clk);
        #1 check_all("held_in_clear");
        clear = 1'b0;

        for (int k = 0; k < 400; k++) begin
            load     = ($urandom_range(0, 7) == 0);
            minCount = 1'($urandom_range(0, 1));
            dec      = ($urandom_range(0, 3) == 0);
            d24      = 5'($urandom_range(0, 31));
            d12      = 4'($urandom_range(0, 15));
            mode12   = 1'($urandom_range(0, 1));
            enable   = ($urandom_range(0, 4) != 0);
            step("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
